// File: rtl/mem_wb_skid_buff_pkg.sv
// Shared definitions for the MEM/WB skid buffer: occupancy state encoding
// and default payload widths.
package mem_wb_skid_buff_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam int unsigned WB_SIZE_DEF = 4;
  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned ALU_W_DEF   = 16;
  localparam int unsigned REG_W_DEF   = 3;

endpackage

// File: rtl/mem_wb_skid_buff_if.sv
// Memory-stage to writeback-stage handshake bundle carried through the
// MEM/WB skid buffer.
interface mem_wb_skid_buff_if
  import mem_wb_skid_buff_pkg::*;
#(
  parameter int unsigned WbSize = WB_SIZE_DEF,
  parameter int unsigned DataW  = DATA_W_DEF,
  parameter int unsigned AluW   = ALU_W_DEF,
  parameter int unsigned RegW   = REG_W_DEF
);
  logic              i_valid;
  logic              i_ready;
  logic [WbSize-1:0] i_WB;
  logic [DataW-1:0]  i_MemData;
  logic [AluW-1:0]   i_alu;
  logic [RegW-1:0]   i_Rdst;

  logic              o_valid;
  logic              o_ready;
  logic [WbSize-1:0] o_WB;
  logic [DataW-1:0]  o_MemData;
  logic [AluW-1:0]   o_alu;
  logic [RegW-1:0]   o_Rdst;
  logic [1:0]        o_count;

  // The buffer itself
  modport slave (
    input  i_valid, i_WB, i_MemData, i_alu, i_Rdst, o_ready,
    output i_ready, o_valid, o_WB, o_MemData, o_alu, o_Rdst, o_count
  );

  // Memory stage / writeback stage driving the buffer
  modport master (
    output i_valid, i_WB, i_MemData, i_alu, i_Rdst, o_ready,
    input  i_ready, o_valid, o_WB, o_MemData, o_alu, o_Rdst, o_count
  );

endinterface

// File: rtl/mem_wb_skid_buff_pipe_slot.sv
// One payload register of the skid buffer: load enable plus synchronous
// active-low clear, updated on the falling clock edge.
module pipe_slot #(
  parameter int unsigned W = 55
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(negedge clk) begin
    if (!rst)
      q <= '0;
    else if (load)
      q <= d;
  end

endmodule

// File: rtl/mem_wb_skid_buff.sv
// MEM/WB pipeline buffer with a one-entry skid slot; the main slot drives the
// writeback outputs, the skid slot absorbs one instruction under back-pressure.
module mem_wb_skid_buff
  import mem_wb_skid_buff_pkg::*;
#(
  parameter int unsigned WbSize = WB_SIZE_DEF,
  parameter int unsigned DataW  = DATA_W_DEF,
  parameter int unsigned AluW   = ALU_W_DEF,
  parameter int unsigned RegW   = REG_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  mem_wb_skid_buff_if.slave     bus
);

  localparam int unsigned SlotW = WbSize + DataW + AluW + RegW;

  state_t             state;
  logic               accept;
  logic               pop;
  logic               main_load;
  logic               skid_load;
  logic [SlotW-1:0]   in_word;
  logic [SlotW-1:0]   main_d;
  logic [SlotW-1:0]   main_q;
  logic [SlotW-1:0]   skid_q;
  logic [WbSize-1:0]  main_wb;

  assign in_word = {bus.i_WB, bus.i_MemData, bus.i_alu, bus.i_Rdst};

  // Flush suppresses every slot load, so a flushed edge captures nothing
  always_comb begin
    accept    = bus.i_valid & (state != FULL);
    pop       = (state != EMPTY) & bus.o_ready;
    main_load = 1'b0;
    skid_load = 1'b0;
    main_d    = in_word;
    if (!flush) begin
      unique case (state)
        EMPTY: main_load = accept;
        ONE: begin
          main_load = accept & pop;
          skid_load = accept & ~pop;
        end
        FULL: begin
          main_load = pop;
          main_d    = skid_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(negedge clk) begin
    if (!rst || flush) begin
      state <= EMPTY;
    end else begin
      unique case (state)
        EMPTY: if (accept) state <= ONE;
        ONE: begin
          if (accept && !pop)      state <= FULL;
          else if (pop && !accept) state <= EMPTY;
        end
        FULL:    if (pop) state <= ONE;
        default: state <= EMPTY;
      endcase
    end
  end

  pipe_slot #(.W(SlotW)) u_main (
    .clk  (clk),
    .rst  (rst),
    .load (main_load),
    .d    (main_d),
    .q    (main_q)
  );

  pipe_slot #(.W(SlotW)) u_skid (
    .clk  (clk),
    .rst  (rst),
    .load (skid_load),
    .d    (in_word),
    .q    (skid_q)
  );

  assign {main_wb, bus.o_MemData, bus.o_alu, bus.o_Rdst} = main_q;

  assign bus.i_ready = (state != FULL);
  assign bus.o_valid = (state != EMPTY);
  assign bus.o_count = state;
  // Stale slot contents stay visible except for the WB controls
  assign bus.o_WB    = (state != EMPTY) ? main_wb : '0;

endmodule

// File: tb/tb_mem_wb_skid_buff.sv
// Bench for mem_wb_skid_buff: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a queue-based model.
module tb_mem_wb_skid_buff;

  typedef struct packed {
    logic [3:0]  wb;
    logic [31:0] md;
    logic [15:0] alu;
    logic [2:0]  rd;
  } ent_t;

  logic clk;
  logic rst;
  logic flush;

  int unsigned checks = 0;
  int unsigned errors = 0;

  ent_t mq[$];
  ent_t m_last;
  bit   model_ready = 1'b0;

  mem_wb_skid_buff_if #(.WbSize(4), .DataW(32), .AluW(16), .RegW(3)) bus ();

  mem_wb_skid_buff #(.WbSize(4), .DataW(32), .AluW(16), .RegW(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  // Falling edge is the active edge; rising edge is the sampling point
  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO of at most two entries, head is what writeback sees
  always @(negedge clk) begin
    ent_t in_e;
    bit   acc;
    bit   pp;
    in_e = '{wb: bus.i_WB, md: bus.i_MemData, alu: bus.i_alu, rd: bus.i_Rdst};
    if (!rst) begin
      mq.delete();
      m_last = '0;
    end else if (flush) begin
      mq.delete();
    end else begin
      acc = bus.i_valid && (mq.size() < 2);
      pp  = (mq.size() > 0) && bus.o_ready;
      if (pp) void'(mq.pop_front());
      if (acc) mq.push_back(in_e);
      if (mq.size() > 0) m_last = mq[0];
    end
    model_ready = 1'b1;
  end

  always @(posedge clk) begin
    if (model_ready) begin
      check("m_valid", 32'(bus.o_valid), 32'(mq.size() != 0));
      check("m_ready", 32'(bus.i_ready), 32'(mq.size() < 2));
      check("m_count", 32'(bus.o_count), 32'(mq.size()));
      check("m_wb",    32'(bus.o_WB), (mq.size() != 0) ? 32'(m_last.wb) : 32'd0);
      check("m_mdata", bus.o_MemData, m_last.md);
      check("m_alu",   32'(bus.o_alu), 32'(m_last.alu));
      check("m_rdst",  32'(bus.o_Rdst), 32'(m_last.rd));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] alu);
    bus.i_valid   = v;
    bus.i_alu     = alu;
    bus.i_WB      = 4'($urandom_range(1, 15));
    bus.i_MemData = $urandom;
    bus.i_Rdst    = 3'($urandom);
  endtask

  initial begin
    rst = 1'b0;
    flush = 1'b0;
    bus.o_ready = 1'b0;
    drive(1'b1, 16'h5555);

    // Reset held for two edges with a valid input present
    tick();
    tick();
    check("rst_valid", 32'(bus.o_valid), 32'd0);
    check("rst_wb",    32'(bus.o_WB), 32'd0);
    check("rst_alu",   32'(bus.o_alu), 32'd0);
    check("rst_ready", 32'(bus.i_ready), 32'd1);
    check("rst_count", 32'(bus.o_count), 32'd0);

    // Streaming at full rate
    rst = 1'b1;
    bus.o_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      drive(1'b1, 16'(k));
      tick();
      check("stream_alu",   32'(bus.o_alu), 32'(k));
      check("stream_count", 32'(bus.o_count), 32'd1);
    end
    drive(1'b0, 16'h0);
    tick();
    check("stream_drain", 32'(bus.o_count), 32'd0);

    // Back-pressure absorbs exactly one extra entry
    bus.o_ready = 1'b0;
    drive(1'b1, 16'hAAAA);
    tick();
    check("bp_first", 32'(bus.o_alu), 32'hAAAA);
    drive(1'b1, 16'hBBBB);
    tick();
    check("bp_count", 32'(bus.o_count), 32'd2);
    check("bp_ready", 32'(bus.i_ready), 32'd0);
    check("bp_head",  32'(bus.o_alu), 32'hAAAA);
    drive(1'b1, 16'hCCCC);
    tick();
    check("bp_held_count", 32'(bus.o_count), 32'd2);
    check("bp_held_head",  32'(bus.o_alu), 32'hAAAA);
    bus.o_ready = 1'b1;
    tick();
    check("bp_second", 32'(bus.o_alu), 32'hBBBB);
    check("bp_second_count", 32'(bus.o_count), 32'd1);
    tick();
    check("bp_third", 32'(bus.o_alu), 32'hCCCC);
    drive(1'b0, 16'h0);
    tick();
    check("bp_empty", 32'(bus.o_count), 32'd0);

    // Flush while full with a simultaneous valid input
    bus.o_ready = 1'b0;
    drive(1'b1, 16'h0011);
    tick();
    drive(1'b1, 16'h0022);
    tick();
    check("fl_full", 32'(bus.o_count), 32'd2);
    flush = 1'b1;
    drive(1'b1, 16'h1234);
    tick();
    check("fl_valid", 32'(bus.o_valid), 32'd0);
    check("fl_wb",    32'(bus.o_WB), 32'd0);
    check("fl_count", 32'(bus.o_count), 32'd0);
    check("fl_ready", 32'(bus.i_ready), 32'd1);
    flush = 1'b0;
    drive(1'b0, 16'h0);
    tick();
    check("fl_kept_slot", 32'(bus.o_alu), 32'h0011);
    check("fl_stays_empty", 32'(bus.o_valid), 32'd0);

    // Reset and flush together: reset clears the slots
    drive(1'b1, 16'h7777);
    tick();
    rst = 1'b0;
    flush = 1'b1;
    drive(1'b1, 16'h8888);
    tick();
    check("pri_valid", 32'(bus.o_valid), 32'd0);
    check("pri_count", 32'(bus.o_count), 32'd0);
    check("pri_alu",   32'(bus.o_alu), 32'd0);
    check("pri_mdata", bus.o_MemData, 32'd0);
    check("pri_rdst",  32'(bus.o_Rdst), 32'd0);
    rst = 1'b1;
    flush = 1'b0;

    // Drain to empty keeps the payload visible, WB gated off
    bus.o_ready = 1'b1;
    drive(1'b1, 16'h0042);
    bus.i_MemData = 32'hDEADBEEF;
    tick();
    check("drain_valid1", 32'(bus.o_valid), 32'd1);
    drive(1'b0, 16'h0);
    tick();
    check("drain_valid0", 32'(bus.o_valid), 32'd0);
    check("drain_wb",     32'(bus.o_WB), 32'd0);
    check("drain_mdata",  bus.o_MemData, 32'hDEADBEEF);

    // Randomized traffic with occasional flush and reset
    for (int n = 0; n < 3000; n++) begin
      drive(1'($urandom_range(0, 3) != 0), 16'($urandom));
      bus.o_ready = 1'($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 39) == 0);
      rst   = ($urandom_range(0, 79) != 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_wb_skid_buff.md
# mem_wb_skid_buff

Parametrised MEM/WB pipeline buffer with a valid/ready handshake and a one-entry skid slot, so the writeback stage can back-pressure memory without losing an instruction. It sits between the memory stage and writeback and carries the WB control bundle, memory read data, ALU result and destination register. It also provides a pipeline flush and squashes writeback controls whenever no valid instruction is presented.

## Interface
- WbSize, 4, width of WB control bundle
- DataW, 32, memory data width
- AluW, 16, ALU result width
- RegW, 3, destination register index width
- clk  in  1  single clock; all state updates on its falling edge
- rst  in  1  reset, synchronous, active-low
- flush  in  1  discard all buffered entries this edge
- i_valid  in  1  memory stage presents an instruction
- i_ready  out  1  buffer accepts this edge
- i_WB  in  WbSize  WB control bundle
- i_MemData  in  DataW  memory read data
- i_alu  in  AluW  ALU result
- i_Rdst  in  RegW  destination register
- o_valid  out  1  writeback sees a valid instruction
- o_ready  in  1  writeback consumes this edge
- o_WB  out  WbSize  WB controls; forced 0 when o_valid=0
- o_MemData, o_alu, o_Rdst  out  DataW/AluW/RegW  payload of head entry
- o_count  out  2  occupancy (0..2)

## Operation
- Two payload slots: main (drives outputs) and skid. State is EMPTY, ONE or FULL.
- i_ready = (state != FULL). It is a function of state only, with no combinational path from o_ready.
- o_valid = (state != EMPTY). o_count = 0, 1 or 2 for EMPTY, ONE and FULL.
- Accept = i_valid & i_ready. Pop = o_valid & o_ready.
- EMPTY:
  - On accept, main<=in and go to ONE.
- ONE:
  - Accept & pop: main<=in, stay ONE.
  - Accept & !pop: skid<=in, go to FULL.
  - Pop & !accept: go to EMPTY.
  - Otherwise hold.
- FULL:
  - Inputs are ignored.
  - On pop, main<=skid and go to ONE.
  - Otherwise hold.
- Priority order: rst=0, then flush=1, then the handshake.
  - Reset: state EMPTY, both slots cleared to 0.
  - Flush: state EMPTY, and no capture on that edge even if i_valid=1.
  - Slot contents are kept after a flush, but o_WB reads 0 because o_valid=0.
- Payload passes through unmodified. No arithmetic and no width conversion.

## Timing
- All registers update on the negedge of clk. Reset is sampled on the same edge.
- Reset values: o_valid=0, i_ready=1, o_count=0, o_WB=0, o_MemData=0, o_alu=0, o_Rdst=0.
- Latency: data accepted on edge N appears on the outputs after edge N.
- Throughput: one instruction per cycle while o_ready=1.
- Holding o_ready=0 for one cycle in ONE absorbs exactly one extra instruction. i_ready drops after that edge.
- Reset or flush asserted mid-stall (FULL) drops both entries. i_ready=1 after the edge.
- Simultaneous flush and accept: flush wins and the entry is lost. The hazard unit re-issues it.
- Outputs are stable between edges. Only o_WB gating is combinational, from state.

## Structure
- A shared package holds:
  - state encodings: EMPTY=2'd0, ONE=2'd1, FULL=2'd2;
  - default widths: 4/32/16/3.
- Sub-module pipe_slot: one payload register (WbSize+DataW+AluW+RegW bits) with load enable and synchronous active-low clear. It is instantiated twice.
- The top level holds the state register, next-state logic, the main-slot input mux (in vs skid) and the o_WB gating.

## Test plan
- Reset: drive rst=0 for 2 edges with i_valid=1 -> o_valid=0, o_WB=0, o_alu=0, i_ready=1, o_count=0.
- Streaming: o_ready=1, send alu=0x0001..0x0005 on back-to-back edges -> o_alu shows 1..5 on consecutive cycles, one edge late, o_count stays 1.
- Back-pressure: send 0xAAAA, then 0xBBBB with o_ready=0 -> o_count=2, i_ready=0, o_alu=0xAAAA. A third input 0xCCCC is held off. Raise o_ready -> 0xAAAA, 0xBBBB, 0xCCCC in order, nothing lost or duplicated.
- Flush while FULL: state FULL, flush=1 with i_valid=1 (alu=0x1234) -> next edge o_valid=0, o_WB=0, o_count=0, i_ready=1, and 0x1234 never appears.
- Priority: rst=0 and flush=1 together with i_valid=1 -> all outputs 0 and state EMPTY.
- Drain to empty: ONE with pop and no input -> o_valid=0 and o_WB=0 while o_MemData keeps its last value.
